// File: rtl/ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg -- arbiter state type, RAM window base and CPU address helper
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UART_ACC = 2'd1,
    UART_ACK = 2'd2
  } arb_state_t;

  localparam logic [31:0] RAM_BASE = 32'h1001_0000;

  typedef struct packed {
    logic        in_range;
    logic [29:0] idx;
  } word_idx_t;

  // The 33-bit compare keeps the window limit exact even for very large RAMs.
  function automatic word_idx_t ram_word_idx(input logic [31:0] addr, input int unsigned aw);
    word_idx_t   r;
    logic [31:0] off;
    off        = addr - RAM_BASE;
    r.idx      = off[31:2];
    r.in_range = (addr >= RAM_BASE) && ({1'b0, off} < (33'd4 << aw));
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_addr_decode.sv
// ----------------------------------------------------------------------------
// ram_addr_decode -- CPU byte address to RAM word index plus window check
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ram_addr_decode
  import ram_arb_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic [BIT_WIDTH-1:0]  i_addr,
  output logic                  o_in_range,
  output logic [ADDR_WIDTH-1:0] o_idx
);

  word_idx_t w_res;

  assign w_res      = ram_word_idx(32'(i_addr), ADDR_WIDTH);
  assign o_in_range = w_res.in_range;
  assign o_idx      = ADDR_WIDTH'(w_res.idx);

endmodule

`default_nettype wire

// File: rtl/ram_uart_arbiter.sv
// ----------------------------------------------------------------------------
// ram_uart_arbiter -- shares the data RAM between the CPU and the UART requester;
// RAM_ARB_STARVE_GUARD_EN enables the bounded UART starvation guard. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ram_uart_arbiter
  import ram_arb_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [BIT_WIDTH-1:0]  cpu_addr,
  input  logic [BIT_WIDTH-1:0]  cpu_wdata,
  output logic [BIT_WIDTH-1:0]  cpu_rdata,
  output logic                  cpu_stall,
  output logic                  cpu_addr_err,
  input  logic                  uart_req,
  input  logic                  uart_we,
  input  logic [ADDR_WIDTH-1:0] uart_addr,
  input  logic [BIT_WIDTH-1:0]  uart_wdata,
  output logic                  uart_ack,
  output logic [BIT_WIDTH-1:0]  uart_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [BIT_WIDTH-1:0]  ram_wdata,
  input  logic [BIT_WIDTH-1:0]  ram_rdata
);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_cpu_idx;
  logic                  w_uart_grant;

  ram_addr_decode #(
    .BIT_WIDTH  (BIT_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_decode (
    .i_addr     (cpu_addr),
    .o_in_range (w_in_range),
    .o_idx      (w_cpu_idx)
  );

  generate
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
      $error("STARVE_MAX must lie in 1..15");
    end
  endgenerate

`ifdef RAM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);
  logic [3:0] r_starve_cnt;

  assign w_uart_grant = uart_req && (!cpu_req || (r_starve_cnt == c_starve_max));

  always_ff @(posedge clk) begin
    if (!rst_n || !uart_req || (r_state == IDLE && w_uart_grant)) begin
      r_starve_cnt <= '0;
    end else if (r_state == IDLE && cpu_req && r_starve_cnt < c_starve_max) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`else
  assign w_uart_grant = uart_req && !cpu_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_uart_grant) w_state_nxt = UART_ACC;
      UART_ACC: w_state_nxt = UART_ACK;
      UART_ACK: w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Out-of-range CPU stores never reach the RAM; reset blocks every write.
  always_comb begin
    ram_addr  = w_cpu_idx;
    ram_wdata = cpu_wdata;
    ram_we    = cpu_req && cpu_we && w_in_range;
    cpu_stall = 1'b0;
    uart_ack  = (r_state == UART_ACK);
    if (r_state == UART_ACC) begin
      ram_addr  = uart_addr;
      ram_wdata = uart_wdata;
      ram_we    = uart_we;
      cpu_stall = cpu_req;
    end
    if (!rst_n) begin
      ram_we    = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  assign cpu_addr_err = cpu_req && !w_in_range;
  assign cpu_rdata    = cpu_addr_err ? '0 : ram_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uart_rdata <= '0;
    end else if (r_state == UART_ACC) begin
      uart_rdata <= ram_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_uart_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_uart_arbiter -- directed and randomized checks against a transaction model
// rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ram_uart_arbiter;

  localparam int          BW   = 32;
  localparam int          AW   = 10;
  localparam int          SM   = 4;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we;
  logic [BW-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_stall, cpu_addr_err;
  logic          uart_req, uart_we, uart_ack;
  logic [AW-1:0] uart_addr;
  logic [BW-1:0] uart_wdata, uart_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ram_uart_arbiter #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_addr_err(cpu_addr_err),
    .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_ack(uart_ack), .uart_rdata(uart_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM macro: combinational read, write on the clock edge.
  logic [BW-1:0] tb_mem [0:(1<<AW)-1];
  logic          mem_init;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  assign ram_rdata = tb_mem[ram_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << AW); i++) tb_mem[i] <= init_word(i);
    end else if (ram_we) begin
      tb_mem[ram_addr] <= ram_wdata;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Transaction-level reference: UART owns the RAM for one cycle after a grant,
  // acks the cycle after that, and a denied request ages toward a forced grant.
  logic [BW-1:0] ref_mem [0:(1<<AW)-1];
  bit            m_acc, m_ack;
  int            m_wait;
  logic [BW-1:0] m_urdata;

  bit            e_stall, e_ack;
  logic          obs_stall, obs_ack, obs_err, obs_ram_we;
  logic [AW-1:0] obs_ram_addr;
  logic [BW-1:0] obs_cpu_rdata, obs_uart_rdata;

  task automatic cycle();
    logic [31:0]   off;
    logic [AW-1:0] idx;
    bit            inr, exp_we, cpu_wr, grant, hit;
    int            nwait;
    #2;
    off = cpu_addr - BASE;
    inr = (cpu_addr >= BASE) && (off < 32'(4 << AW));
    idx = off[AW+1:2];
    obs_stall = cpu_stall; obs_ack = uart_ack; obs_err = cpu_addr_err;
    obs_ram_we = ram_we; obs_ram_addr = ram_addr;
    obs_cpu_rdata = cpu_rdata; obs_uart_rdata = uart_rdata;
    e_stall = rst_n && m_acc && cpu_req;
    e_ack   = m_ack;
    exp_we  = rst_n && (m_acc ? uart_we : (cpu_req && cpu_we && inr));
    check_eq("stall", 32'(cpu_stall), 32'(e_stall));
    check_eq("ack", 32'(uart_ack), 32'(e_ack));
    check_eq("addr_err", 32'(cpu_addr_err), 32'(cpu_req && !inr));
    check_eq("uart_rdata", uart_rdata, m_urdata);
    check_eq("ram_we", 32'(ram_we), 32'(exp_we));
    if (exp_we) begin
      check_eq("ram_addr", 32'(ram_addr), m_acc ? 32'(uart_addr) : 32'(idx));
      check_eq("ram_wdata", ram_wdata, m_acc ? uart_wdata : cpu_wdata);
    end
    if (cpu_req && !cpu_we && !m_acc)
      check_eq("cpu_rdata", cpu_rdata, inr ? ref_mem[idx] : 32'd0);
`ifdef RAM_ARB_STARVE_GUARD_EN
    hit = (m_wait == SM);
`else
    hit = 1'b0;
`endif
    cpu_wr = cpu_req && cpu_we && inr && !m_acc;
    grant  = !m_acc && !m_ack && uart_req && (!cpu_req || hit);
    if (!uart_req || grant) nwait = 0;
    else if (!m_acc && !m_ack && cpu_req && m_wait < SM) nwait = m_wait + 1;
    else nwait = m_wait;
    @(posedge clk);
    if (!rst_n) begin
      m_acc = 0; m_ack = 0; m_wait = 0; m_urdata = '0;
    end else begin
      if (m_acc) begin
        m_urdata = ref_mem[uart_addr];
        if (uart_we) ref_mem[uart_addr] = uart_wdata;
      end else if (cpu_wr) begin
        ref_mem[idx] = cpu_wdata;
      end
      m_wait = nwait;
      m_ack  = m_acc;
      m_acc  = grant;
    end
    #1;
  endtask

  task automatic run_until_ack(input int limit, output int lat, output int nst);
    lat = -1; nst = 0;
    for (int n = 0; n < limit; n++) begin
      cycle();
      nst += int'(obs_stall);
      if (obs_ack) begin
        lat = n;
        break;
      end
    end
  endtask

  int            lat, nst;
  logic [BW-1:0] saved;

  initial begin
    rst_n = 0; mem_init = 1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    uart_req = 0; uart_we = 0; uart_addr = '0; uart_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    m_acc = 0; m_ack = 0; m_wait = 0; m_urdata = '0;
    @(posedge clk); #1;
    cycle();
    mem_init = 0; rst_n = 1;
    cycle();
    check_eq("rst_ack", 32'(obs_ack), 32'd0);
    check_eq("rst_urdata", obs_uart_rdata, 32'd0);

    // UART write then read of word 5 with the CPU idle
    uart_req = 1; uart_we = 1; uart_addr = 5; uart_wdata = 32'hDEAD_BEEF;
    run_until_ack(8, lat, nst);
    check_eq("uwr_lat", 32'(lat), 32'd2);
    uart_we = 0;
    run_until_ack(8, lat, nst);
    check_eq("urd_lat", 32'(lat), 32'd2);
    uart_req = 0;
    cycle();
    check_eq("urd_data", obs_uart_rdata, 32'hDEAD_BEEF);

    // CPU store and load through the window
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h1001_0014; cpu_wdata = 32'h1234_5678;
    cycle();
    check_eq("st_addr", 32'(obs_ram_addr), 32'd5);
    check_eq("st_we", 32'(obs_ram_we), 32'd1);
    cpu_we = 0;
    cycle();
    check_eq("ld_data", obs_cpu_rdata, 32'h1234_5678);

    // Out-of-range load
    cpu_addr = 32'h0040_0000;
    cycle();
    check_eq("oor_err", 32'(obs_err), 32'd1);
    check_eq("oor_rdata", obs_cpu_rdata, 32'd0);
    check_eq("oor_we", 32'(obs_ram_we), 32'd0);
    check_eq("oor_stall", 32'(obs_stall), 32'd0);

    // Continuous CPU traffic against a UART read
    cpu_addr = BASE; uart_req = 1; uart_we = 0; uart_addr = 5;
`ifdef RAM_ARB_STARVE_GUARD_EN
    run_until_ack(12, lat, nst);
    check_eq("starve_lat", 32'(lat), 32'(SM + 2));
    check_eq("starve_stalls", 32'(nst), 32'd1);
    uart_req = 0;
`else
    run_until_ack(10, lat, nst);
    check_eq("prio_noack", 32'(lat), 32'hFFFF_FFFF);
    check_eq("prio_stalls", 32'(nst), 32'd0);
    cpu_req = 0;
    run_until_ack(5, lat, nst);
    check_eq("prio_lat", 32'(lat), 32'd2);
    uart_req = 0;
`endif
    cpu_req = 0;
    cycle();

    // Reset during the UART access cycle
    uart_req = 1; uart_we = 1; uart_addr = 7; uart_wdata = 32'hCAFE_F00D;
    saved = ref_mem[7];
    cycle();
    rst_n = 0;
    cycle();
    rst_n = 1; uart_req = 0;
    cycle();
    check_eq("rstacc_ack", 32'(obs_ack), 32'd0);
    check_eq("rstacc_urdata", obs_uart_rdata, 32'd0);
    check_eq("rstacc_mem", tb_mem[7], saved);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (!e_stall) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_wdata = $urandom;
        case ($urandom_range(0, 7))
          0:       cpu_addr = $urandom;
          1:       cpu_addr = BASE + 32'h0FF8 + 32'($urandom_range(0, 15));
          2:       cpu_addr = BASE - 32'($urandom_range(1, 4));
          default: cpu_addr = BASE + 32'($urandom_range(0, 63));
        endcase
      end
      if (!uart_req || e_ack) begin
        uart_req   = ($urandom_range(0, 2) == 0) || (uart_req && $urandom_range(0, 1) == 1);
        uart_we    = 1'($urandom_range(0, 1));
        uart_addr  = AW'($urandom_range(0, 15));
        uart_wdata = $urandom;
      end
      rst_n = ($urandom_range(0, 149) != 0);
      cycle();
    end
    rst_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
